// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the single-cycle writeback (s0) and the
// multi-cycle writeback (s1), and tracks registers that still have a multi-cycle write pending.
module regfile_wb_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_s0_valid,
  output logic        o_s0_ready,
  input  logic [4:0]  i_s0_addr,
  input  logic [31:0] i_s0_data,
  input  logic        i_s1_valid,
  output logic        o_s1_ready,
  input  logic [4:0]  i_s1_addr,
  input  logic [31:0] i_s1_data,
  input  logic        i_mark_valid,
  input  logic [4:0]  i_mark_addr,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic [31:0] o_busy_vec,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          s1_prio, s0_gnt, s1_gnt, gnt_any;
  logic [4:0]    gnt_addr;
  logic [31:0]   gnt_data;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_wren_q, rd_wren_d;
  logic [31:0]   busy_q, busy_d;

  // Readies are masked by reset so nothing handshakes while the block is held in reset.
  always_comb begin
    s1_prio  = i_s1_valid && (wait_cnt_q == MAX_WAIT_C);
    s1_gnt   = i_reset && i_s1_valid && (s1_prio || !i_s0_valid);
    s0_gnt   = i_reset && i_s0_valid && !s1_prio;
    gnt_any  = s0_gnt || s1_gnt;
    gnt_addr = s1_gnt ? i_s1_addr : i_s0_addr;
    gnt_data = s1_gnt ? i_s1_data : i_s0_data;
  end

  assign o_s0_ready = s0_gnt;
  assign o_s1_ready = s1_gnt;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_s1_valid || s1_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    rd_wren_d = 1'b0;
    if (gnt_any) begin
      rd_addr_d = gnt_addr;
      rd_data_d = gnt_data;
      rd_wren_d = (gnt_addr != 5'd0);
    end
  end

  // A set on the same edge as the clear wins: a new producer was just issued.
  assign busy_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      always_comb begin
        busy_d[gi] = (i_mark_valid && (i_mark_addr == 5'(gi))) ||
                     (busy_q[gi] && !(rd_wren_q && (rd_addr_q == 5'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wait_cnt_q <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_wren_q  <= 1'b0;
      busy_q     <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_wren_q  <= rd_wren_d;
      busy_q     <= busy_d;
    end
  end

  assign o_rd_addr  = rd_addr_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_wren  = rd_wren_q;
  assign o_busy_vec = busy_q;
  assign o_rs1_busy = busy_q[i_rs1_addr];
  assign o_rs2_busy = busy_q[i_rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single grant, starvation rotation,
// x0 writes, scoreboard set/clear/collision and reset in the middle of a write.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [4:0]  s0_addr, s1_addr, mark_addr, rs1_addr, rs2_addr, rd_addr;
  logic [31:0] s0_data, s1_data, busy_vec, rd_data;
  logic        mark_valid, rs1_busy, rs2_busy, rd_wren;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.MAX_WAIT(4)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_s0_valid(s0_valid), .o_s0_ready(s0_ready), .i_s0_addr(s0_addr), .i_s0_data(s0_data),
    .i_s1_valid(s1_valid), .o_s1_ready(s1_ready), .i_s1_addr(s1_addr), .i_s1_data(s1_data),
    .i_mark_valid(mark_valid), .i_mark_addr(mark_addr),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy), .o_busy_vec(busy_vec),
    .o_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_wren(rd_wren)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
    s1_valid = 1'b1; s1_addr = 5'd9; s1_data = 32'hCAFEF00D;
    mark_valid = 1'b1; mark_addr = 5'd3;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    repeat (3) tick;
    #1;
    chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
    chk("rst_s1_ready", {31'd0, s1_ready}, 32'd0);
    chk("rst_wren", {31'd0, rd_wren}, 32'd0);
    chk("rst_addr", {27'd0, rd_addr}, 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_busy_vec", busy_vec, 32'd0);

    // Release reset with both sources requesting: s0 wins first, s1 every 5th cycle.
    mark_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("starve_s0_ready_%0d", k), {31'd0, s0_ready}, {31'd0, (k % 5) != 4});
      chk($sformatf("starve_s1_ready_%0d", k), {31'd0, s1_ready}, {31'd0, (k % 5) == 4});
      tick;
      chk($sformatf("starve_wren_%0d", k), {31'd0, rd_wren}, 32'd1);
      chk($sformatf("starve_addr_%0d", k), {27'd0, rd_addr}, ((k % 5) == 4) ? 32'd9 : 32'd5);
      chk($sformatf("starve_data_%0d", k), rd_data, ((k % 5) == 4) ? 32'hCAFEF00D : 32'hDEADBEEF);
      #1;
    end

    // Lone s0 write
    s1_valid = 1'b0;
    s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
    #1;
    chk("single_s0_ready", {31'd0, s0_ready}, 32'd1);
    chk("single_s1_ready", {31'd0, s1_ready}, 32'd0);
    tick;
    s0_valid = 1'b0;
    chk("single_wren", {31'd0, rd_wren}, 32'd1);
    chk("single_addr", {27'd0, rd_addr}, 32'd5);
    chk("single_data", rd_data, 32'hDEADBEEF);

    // x0 write from s1 completes the handshake without a write enable
    s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h1234;
    #1;
    chk("x0_s1_ready", {31'd0, s1_ready}, 32'd1);
    tick;
    s1_valid = 1'b0;
    chk("x0_wren", {31'd0, rd_wren}, 32'd0);
    chk("x0_data", rd_data, 32'h1234);
    tick;
    chk("idle_wren", {31'd0, rd_wren}, 32'd0);
    chk("idle_hold_data", rd_data, 32'h1234);

    // Scoreboard: mark x7 busy
    mark_valid = 1'b1; mark_addr = 5'd7;
    #1;
    chk("sb_pre_mark", busy_vec, 32'd0);
    tick;
    mark_valid = 1'b1; mark_addr = 5'd0;
    rs1_addr = 5'd7; rs2_addr = 5'd0;
    #1;
    chk("sb_rs1_busy", {31'd0, rs1_busy}, 32'd1);
    chk("sb_rs2_busy_x0", {31'd0, rs2_busy}, 32'd0);
    chk("sb_vec_mark7", busy_vec, 32'h0000_0080);
    tick;
    mark_valid = 1'b0;
    chk("sb_mark_x0_ignored", busy_vec, 32'h0000_0080);

    // s1 writes x7: busy stays up while the write is presented, clears after
    s1_valid = 1'b1; s1_addr = 5'd7; s1_data = 32'h77;
    #1;
    chk("sb_s1_ready", {31'd0, s1_ready}, 32'd1);
    tick;
    s1_valid = 1'b0;
    chk("sb_wren7", {31'd0, rd_wren}, 32'd1);
    chk("sb_no_bypass", {31'd0, rs1_busy}, 32'd1);
    tick;
    chk("sb_cleared_vec", busy_vec, 32'd0);
    chk("sb_cleared_rs1", {31'd0, rs1_busy}, 32'd0);

    // Same-edge set and clear on x7: set wins
    mark_valid = 1'b1; mark_addr = 5'd7;
    tick;
    mark_valid = 1'b0;
    s1_valid = 1'b1; s1_addr = 5'd7;
    tick;
    s1_valid = 1'b0;
    mark_valid = 1'b1; mark_addr = 5'd7;
    chk("col_wren", {31'd0, rd_wren}, 32'd1);
    tick;
    mark_valid = 1'b0;
    chk("col_set_wins", busy_vec, 32'h0000_0080);
    tick;
    chk("col_still_set", busy_vec, 32'h0000_0080);

    // Clear from s0 is honoured too
    s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'h70;
    tick;
    s0_valid = 1'b0;
    tick;
    chk("s0_clear_vec", busy_vec, 32'd0);

    // Reset in the cycle after a grant, with busy bits set
    mark_valid = 1'b1; mark_addr = 5'd12;
    tick;
    mark_addr = 5'd20;
    tick;
    mark_valid = 1'b0;
    chk("mid_busy_before", busy_vec, 32'h0010_1000);
    s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h33;
    tick;
    chk("mid_wren_before", {31'd0, rd_wren}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_wren_rst", {31'd0, rd_wren}, 32'd0);
    chk("mid_busy_rst", busy_vec, 32'd0);
    chk("mid_addr_rst", {27'd0, rd_addr}, 32'd0);
    chk("mid_s0_ready_rst", {31'd0, s0_ready}, 32'd0);
    tick;
    s0_valid = 1'b0;
    rst_n = 1'b1;
    rs1_addr = 5'd12;
    tick;
    chk("post_rst_rs1", {31'd0, rs1_busy}, 32'd0);
    chk("post_rst_wren", {31'd0, rd_wren}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
